// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexes a 16-bit value onto a 4-digit common-anode 7-segment display
// as hex. The value is snapshotted once per scan frame so a digit never tears.
// Optional build macro: SEG7_LEADING_ZERO_BLANK_EN (blanks leading zero digits 3..1).
`timescale 1ns/1ps

module seg7_scan_driver #(
  parameter int REFRESH_DIV = 10000,  // clk cycles per digit slot, >= 2
  parameter int BLANK_CYC   = 8       // anode-off cycles at slot start, < REFRESH_DIV
) (
  input  logic        clk_10MHz_i,
  input  logic        rst_i,
  input  logic [15:0] data_i,
  input  logic        en_i,
  output logic [3:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic        frame_o
);

  localparam int            PW         = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYC);

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          frame_q, frame_d;

  logic          tick;
  logic          boundary;
  logic [3:0]    digit_nib;
  logic          digit_blank;

  // Hex digit to active-low gfedcba segment pattern.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // lead_zero[k]: nibble k and every nibble above it are zero.
  logic [3:1] lead_zero;
  genvar gi;
  generate
    for (gi = 1; gi < 4; gi++) begin : g_lead_zero
      assign lead_zero[gi] = (shadow_q[15:4*gi] == '0);
    end
  endgenerate
`endif

  // Select the nibble for the current slot and decide whether it is suppressed.
  always_comb begin
    digit_nib   = shadow_q[3:0];
    digit_blank = 1'b0;
    case (idx_q)
      2'd0: digit_nib = shadow_q[3:0];
      2'd1: digit_nib = shadow_q[7:4];
      2'd2: digit_nib = shadow_q[11:8];
      default: digit_nib = shadow_q[15:12];
    endcase
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    case (idx_q)
      2'd1: digit_blank = lead_zero[1];
      2'd2: digit_blank = lead_zero[2];
      2'd3: digit_blank = lead_zero[3];
      default: digit_blank = 1'b0;  // digit 0 always shown
    endcase
`endif
  end

  // Next-state for the slot prescaler, digit index, snapshot and output registers.
  always_comb begin
    tick     = (presc_q == PRESC_LAST);
    boundary = tick && (idx_q == 2'd3);
    presc_d  = presc_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    an_d     = 4'hF;
    seg_d    = 7'h7F;
    frame_d  = 1'b0;
    if (!en_i) begin
      // Display dark; keep tracking the input so re-enable shows a fresh value.
      presc_d  = '0;
      idx_d    = 2'd0;
      shadow_d = data_i;
    end else begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        idx_d = idx_q + 2'd1;
      end
      if (boundary) begin
        shadow_d = data_i;
      end
      frame_d = boundary;
      if ((presc_q >= BLANK_END) && !digit_blank) begin
        an_d  = ~(4'b0001 << idx_q);
        seg_d = hex7(digit_nib);
      end
    end
  end

  // State and output registers; reset forces the display dark at once.
  always_ff @(posedge clk_10MHz_i or posedge rst_i) begin
    if (rst_i) begin
      presc_q  <= '0;
      idx_q    <= 2'd0;
      shadow_q <= 16'h0000;
      an_q     <= 4'hF;
      seg_q    <= 7'h7F;
      frame_q  <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      frame_q  <= frame_d;
    end
  end

  assign an_o    = an_q;
  assign seg_o   = seg_q;
  assign frame_o = frame_q;
  assign dp_o    = 1'b1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver with REFRESH_DIV=4, BLANK_CYC=1.
`timescale 1ns/1ps

module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] data;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame;

  int total = 0;
  int bad   = 0;

  always #50 clk = ~clk;

  seg7_scan_driver #(.REFRESH_DIV(4), .BLANK_CYC(1)) dut (
    .clk_10MHz_i (clk),
    .rst_i       (rst),
    .data_i      (data),
    .en_i        (en),
    .an_o        (an),
    .seg_o       (seg),
    .dp_o        (dp),
    .frame_o     (frame)
  );

  typedef struct {
    logic        en;
    logic [15:0] data;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input logic e, input logic [15:0] d, input logic [3:0] a,
                     input logic [6:0] s, input logic f);
    vec_t v;
    v.en = e; v.data = d; v.an = a; v.seg = s; v.frame = f;
    vecs.push_back(v);
  endtask

  // One enabled slot: a blank cycle then three cycles of the digit.
  task automatic add_slot(input logic [15:0] d, input logic [3:0] a,
                          input logic [6:0] s, input logic f_last);
    add(1'b1, d, 4'hF, 7'h7F, 1'b0);
    add(1'b1, d, a, s, 1'b0);
    add(1'b1, d, a, s, 1'b0);
    add(1'b1, d, a, s, f_last);
  endtask

  initial begin
    logic [3:0] an_exp [4];
    logic [6:0] seg_exp [4];
    logic       lzb;
    int         last_frame;
    int         n_frames;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    lzb = 1'b1;
`else
    lzb = 1'b0;
`endif

    // Stimulus table: disabled preload, frame of 1234 with data changing in slot 1,
    // then a frame of ABCD.
    for (int i = 0; i < 5; i++) add(1'b0, 16'h1234, 4'hF, 7'h7F, 1'b0);
    add_slot(16'h1234, 4'hE, 7'h19, 1'b0);
    add_slot(16'hABCD, 4'hD, 7'h30, 1'b0);
    add_slot(16'hABCD, 4'hB, 7'h24, 1'b0);
    add_slot(16'hABCD, 4'h7, 7'h79, 1'b1);
    add_slot(16'hABCD, 4'hE, 7'h21, 1'b0);
    add_slot(16'hABCD, 4'hD, 7'h46, 1'b0);
    add_slot(16'hABCD, 4'hB, 7'h03, 1'b0);
    add_slot(16'hABCD, 4'h7, 7'h08, 1'b1);

    // Reset state
    rst = 1'b1; en = 1'b0; data = 16'h0000;
    #1;
    check("reset_an", an, 4'hF);
    check("reset_seg", seg, 7'h7F);
    check("reset_dp", dp, 1'b1);
    check("reset_frame", frame, 1'b0);
    step();
    step();
    rst = 1'b0;

    // Table-driven scan and snapshot
    for (int i = 0; i < vecs.size(); i++) begin
      en   = vecs[i].en;
      data = vecs[i].data;
      step();
      $display("vec %0d en=%b data=%h an=%h seg=%h frame=%b", i, en, data, an, seg, frame);
      check($sformatf("vec%0d_an", i), an, vecs[i].an);
      check($sformatf("vec%0d_seg", i), seg, vecs[i].seg);
      check($sformatf("vec%0d_frame", i), frame, vecs[i].frame);
    end

    // Advance into slot 2 (second cycle of digit 2 visible), then disable
    for (int j = 1; j <= 10; j++) step();
    check("midslot2_an", an, 4'hB);
    check("midslot2_seg", seg, 7'h03);
    en = 1'b0;
    data = 16'h0005;
    for (int j = 0; j < 4; j++) begin
      step();
      $display("disabled cycle %0d an=%h seg=%h frame=%b", j, an, seg, frame);
      check($sformatf("dis%0d_an", j), an, 4'hF);
      check($sformatf("dis%0d_seg", j), seg, 7'h7F);
      check($sformatf("dis%0d_frame", j), frame, 1'b0);
    end

    // Re-enable with 0005: three full frames, checking every cycle
    an_exp[0] = 4'hE; an_exp[1] = 4'hD; an_exp[2] = 4'hB; an_exp[3] = 4'h7;
    seg_exp[0] = 7'h12; seg_exp[1] = 7'h40; seg_exp[2] = 7'h40; seg_exp[3] = 7'h40;
    en = 1'b1;
    last_frame = -1;
    n_frames = 0;
    for (int i = 0; i < 48; i++) begin
      int slot;
      int ph;
      logic dark;
      slot = (i % 16) / 4;
      ph   = i % 4;
      dark = (ph == 0) || (lzb && slot != 0);
      step();
      $display("run %0d an=%h seg=%h frame=%b", i, an, seg, frame);
      check($sformatf("run%0d_an", i), an, dark ? 4'hF : an_exp[slot]);
      check($sformatf("run%0d_seg", i), seg, dark ? 7'h7F : seg_exp[slot]);
      check($sformatf("run%0d_frame", i), frame, (i % 16) == 15);
      if (frame === 1'b1) begin
        if (last_frame >= 0) check($sformatf("frame_period_at%0d", i), i - last_frame, 16);
        last_frame = i;
        n_frames++;
      end
    end
    check("frame_count", n_frames, 3);

    // Asynchronous reset while digit 0 is lit
    step();
    step();
    check("prerst_an", an, 4'hE);
    check("prerst_seg", seg, 7'h12);
    rst = 1'b1;
    #1;
    check("asyncrst_an", an, 4'hF);
    check("asyncrst_seg", seg, 7'h7F);
    check("asyncrst_dp", dp, 1'b1);
    check("asyncrst_frame", frame, 1'b0);
    step();
    check("rsthold_an", an, 4'hF);
    rst = 1'b0;

    // After release: slot 0 first, shadow cleared to 0000
    step();
    check("post_blank_an", an, 4'hF);
    for (int j = 0; j < 3; j++) begin
      step();
      check($sformatf("post_d0_%0d_an", j), an, 4'hE);
      check($sformatf("post_d0_%0d_seg", j), seg, 7'h40);
      check($sformatf("post_d0_%0d_frame", j), frame, 1'b0);
    end
    step();
    check("post_s1_blank_an", an, 4'hF);
    step();
    check("post_s1_an", an, lzb ? 4'hF : 4'hD);
    check("post_s1_seg", seg, lzb ? 7'h7F : 7'h40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
